// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the shared-memory-bus arbiter.
// Holds the FSM state encoding, the arbitration mode codes and the strobe-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARB_FIXED       = 0;
  localparam int ARB_ROUND_ROBIN = 1;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection for the arbiter.
// Produces the winner as both a one-hot vector and an index, plus an any-request flag.
module arb_picker
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 mode,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     grant_idx,
  output logic                 any_req
);

  int   cand_s;
  logic found_s;

  // Scan from index 0 (fixed) or from the slot after ptr (round-robin); first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (mode) begin
        cand_s = (int'(ptr) + 1 + k) % NUM_PORTS;
      end else begin
        cand_s = k;
      end
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        grant_idx = PTR_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant = '0;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter for the single shared memory bus; one transaction in flight at a time.
// Latches the winning request, drives the bus, returns a one-cycle completion pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_PORTS-1:0]                        req_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]             req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]             req_wdata,
  input  logic [NUM_PORTS*strb_width(DATA_WIDTH)-1:0] req_wstrb,
  input  logic [NUM_PORTS-1:0]                        req_instr,
  output logic [NUM_PORTS-1:0]                        req_valid,
  output logic                                        req_err,
  output logic [DATA_WIDTH-1:0]                       req_rdata,
  output logic                                        mem_ready,
  input  logic                                        mem_valid,
  output logic [ADDR_WIDTH-1:0]                       mem_addr,
  output logic [DATA_WIDTH-1:0]                       mem_wdata,
  output logic [strb_width(DATA_WIDTH)-1:0]           mem_wstrb,
  output logic                                        mem_instr,
  input  logic [DATA_WIDTH-1:0]                       mem_rdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int PTR_W  = $clog2(NUM_PORTS);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);

  state_t                 state_r, state_nxt_s;
  logic                   mem_ready_r, mem_ready_nxt_s;
  logic [ADDR_WIDTH-1:0]  mem_addr_r, mem_addr_nxt_s;
  logic [DATA_WIDTH-1:0]  mem_wdata_r, mem_wdata_nxt_s;
  logic [STRB_W-1:0]      mem_wstrb_r, mem_wstrb_nxt_s;
  logic                   mem_instr_r, mem_instr_nxt_s;
  logic [PTR_W-1:0]       grant_idx_r, grant_idx_nxt_s;
  logic [NUM_PORTS-1:0]   grant_oh_r, grant_oh_nxt_s;
  logic [PTR_W-1:0]       ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]       wd_cnt_r, wd_cnt_nxt_s;
  logic [NUM_PORTS-1:0]   req_valid_r, req_valid_nxt_s;
  logic                   req_err_r, req_err_nxt_s;
  logic [DATA_WIDTH-1:0]  req_rdata_r, req_rdata_nxt_s;

  logic [NUM_PORTS-1:0]   pick_grant_s;
  logic [PTR_W-1:0]       pick_idx_s;
  logic                   pick_any_s;

  arb_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req       (req_ready),
    .ptr       (ptr_r),
    .mode      (ARB_MODE == ARB_ROUND_ROBIN),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s),
    .any_req   (pick_any_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s     = state_r;
    mem_ready_nxt_s = mem_ready_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_wstrb_nxt_s = mem_wstrb_r;
    mem_instr_nxt_s = mem_instr_r;
    grant_idx_nxt_s = grant_idx_r;
    grant_oh_nxt_s  = grant_oh_r;
    ptr_nxt_s       = ptr_r;
    wd_cnt_nxt_s    = wd_cnt_r;
    req_valid_nxt_s = '0;
    req_err_nxt_s   = 1'b0;
    req_rdata_nxt_s = req_rdata_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          mem_addr_nxt_s  = req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_nxt_s = req_wdata[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
          mem_wstrb_nxt_s = req_wstrb[pick_idx_s*STRB_W +: STRB_W];
          mem_instr_nxt_s = req_instr[pick_idx_s];
          mem_ready_nxt_s = 1'b1;
          grant_idx_nxt_s = pick_idx_s;
          grant_oh_nxt_s  = pick_grant_s;
          wd_cnt_nxt_s    = '0;
          state_nxt_s     = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // A completion in the same cycle as the watchdog expiry takes precedence.
        if (mem_valid) begin
          req_rdata_nxt_s = mem_rdata;
          req_valid_nxt_s = grant_oh_r;
          mem_ready_nxt_s = 1'b0;
          ptr_nxt_s       = grant_idx_r;
          wd_cnt_nxt_s    = '0;
          state_nxt_s     = DONE;
        end else if ((TIMEOUT > 0) && (wd_cnt_r == CNT_MAX)) begin
          req_rdata_nxt_s = '0;
          req_valid_nxt_s = grant_oh_r;
          req_err_nxt_s   = 1'b1;
          mem_ready_nxt_s = 1'b0;
          wd_cnt_nxt_s    = '0;
          state_nxt_s     = DONE;
        end else begin
          wd_cnt_nxt_s = wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt_s  = BUSY;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s     = IDLE;
        mem_ready_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_ready_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wstrb_r <= '0;
      mem_instr_r <= 1'b0;
      grant_idx_r <= '0;
      grant_oh_r  <= '0;
      ptr_r       <= PTR_RST;
      wd_cnt_r    <= '0;
      req_valid_r <= '0;
      req_err_r   <= 1'b0;
      req_rdata_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      mem_ready_r <= mem_ready_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_wstrb_r <= mem_wstrb_nxt_s;
      mem_instr_r <= mem_instr_nxt_s;
      grant_idx_r <= grant_idx_nxt_s;
      grant_oh_r  <= grant_oh_nxt_s;
      ptr_r       <= ptr_nxt_s;
      wd_cnt_r    <= wd_cnt_nxt_s;
      req_valid_r <= req_valid_nxt_s;
      req_err_r   <= req_err_nxt_s;
      req_rdata_r <= req_rdata_nxt_s;
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_instr = mem_instr_r;
  assign req_valid = req_valid_r;
  assign req_err   = req_err_r;
  assign req_rdata = req_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter with a 4-cycle watchdog and a
// 3-port round-robin arbiter without one, both driven from one linear sequence.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 2-port, fixed priority, TIMEOUT=4
  logic        f_reset;
  logic [1:0]  f_req_ready, f_req_instr, f_req_valid;
  logic [63:0] f_req_addr, f_req_wdata;
  logic [7:0]  f_req_wstrb;
  logic        f_req_err, f_mem_ready, f_mem_valid, f_mem_instr;
  logic [31:0] f_req_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic [3:0]  f_mem_wstrb;

  // 3-port, round-robin, no watchdog
  logic        r_reset;
  logic [2:0]  r_req_ready, r_req_instr, r_req_valid;
  logic [95:0] r_req_addr, r_req_wdata;
  logic [11:0] r_req_wstrb;
  logic        r_req_err, r_mem_ready, r_mem_valid, r_mem_instr;
  logic [31:0] r_req_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic [3:0]  r_mem_wstrb;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(4)) u_fix (
    .clk(clk), .reset(f_reset), .req_ready(f_req_ready), .req_addr(f_req_addr),
    .req_wdata(f_req_wdata), .req_wstrb(f_req_wstrb), .req_instr(f_req_instr),
    .req_valid(f_req_valid), .req_err(f_req_err), .req_rdata(f_req_rdata),
    .mem_ready(f_mem_ready), .mem_valid(f_mem_valid), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_wstrb(f_mem_wstrb), .mem_instr(f_mem_instr),
    .mem_rdata(f_mem_rdata)
  );

  mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(0)) u_rr (
    .clk(clk), .reset(r_reset), .req_ready(r_req_ready), .req_addr(r_req_addr),
    .req_wdata(r_req_wdata), .req_wstrb(r_req_wstrb), .req_instr(r_req_instr),
    .req_valid(r_req_valid), .req_err(r_req_err), .req_rdata(r_req_rdata),
    .mem_ready(r_mem_ready), .mem_valid(r_mem_valid), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_wstrb(r_mem_wstrb), .mem_instr(r_mem_instr),
    .mem_rdata(r_mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_order [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

  initial begin
    f_reset = 1'b1; f_req_ready = 2'b00; f_req_instr = 2'b00;
    f_req_addr = 64'h0; f_req_wdata = 64'h0; f_req_wstrb = 8'h00;
    f_mem_valid = 1'b0; f_mem_rdata = 32'h0;
    r_reset = 1'b1; r_req_ready = 3'b000; r_req_instr = 3'b000;
    r_req_addr = {32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
    r_req_wdata = 96'h0; r_req_wstrb = 12'h000;
    r_mem_valid = 1'b0; r_mem_rdata = 32'h0;
    tick(); tick();
    f_reset = 1'b0; r_reset = 1'b0;
    chk("rst_mem_ready", {63'h0, f_mem_ready}, 64'h0);
    chk("rst_req_valid", {62'h0, f_req_valid}, 64'h0);
    chk("rst_req_err",   {63'h0, f_req_err}, 64'h0);
    chk("rst_req_rdata", {32'h0, f_req_rdata}, 64'h0);
    chk("rst_mem_addr",  {32'h0, f_mem_addr}, 64'h0);

    // fixed priority: both request, port 0 wins
    f_req_addr = {32'h0000_0200, 32'h0000_0100};
    f_req_instr = 2'b01;
    f_req_ready = 2'b11;
    tick();
    chk("fp_grant_ready", {63'h0, f_mem_ready}, 64'h1);
    chk("fp_grant_addr",  {32'h0, f_mem_addr}, 64'h100);
    chk("fp_grant_instr", {63'h0, f_mem_instr}, 64'h1);
    tick(); tick();
    f_mem_valid = 1'b1; f_mem_rdata = 32'hDEAD_BEEF;
    tick();
    f_mem_valid = 1'b0;
    chk("fp_done_valid", {62'h0, f_req_valid}, 64'h1);
    chk("fp_done_rdata", {32'h0, f_req_rdata}, 64'hDEAD_BEEF);
    chk("fp_done_err",   {63'h0, f_req_err}, 64'h0);
    chk("fp_done_ready", {63'h0, f_mem_ready}, 64'h0);
    f_req_ready = 2'b10;
    tick();
    chk("fp_idle_valid", {62'h0, f_req_valid}, 64'h0);
    chk("fp_idle_ready", {63'h0, f_mem_ready}, 64'h0);
    tick();
    chk("fp_p1_ready", {63'h0, f_mem_ready}, 64'h1);
    chk("fp_p1_addr",  {32'h0, f_mem_addr}, 64'h200);
    f_mem_valid = 1'b1; f_mem_rdata = 32'h1111_1111;
    tick();
    f_mem_valid = 1'b0; f_req_ready = 2'b00;
    chk("fp_p1_valid", {62'h0, f_req_valid}, 64'h2);
    tick();

    // spurious completion while idle
    f_mem_valid = 1'b1; f_mem_rdata = 32'h1234_5678;
    tick();
    chk("sp_valid", {62'h0, f_req_valid}, 64'h0);
    chk("sp_rdata", {32'h0, f_req_rdata}, 64'h1111_1111);
    tick();
    chk("sp_rdata2", {32'h0, f_req_rdata}, 64'h1111_1111);
    chk("sp_ready",  {63'h0, f_mem_ready}, 64'h0);
    f_mem_valid = 1'b0;

    // write passthrough on port 1, requester changes ignored in BUSY
    f_req_addr = {32'h0000_0040, 32'h0};
    f_req_wdata = {32'h0000_ABCD, 32'h0};
    f_req_wstrb = {4'b0011, 4'b0000};
    f_req_instr = 2'b00;
    f_req_ready = 2'b10;
    tick();
    chk("wr_addr",  {32'h0, f_mem_addr}, 64'h40);
    chk("wr_wstrb", {60'h0, f_mem_wstrb}, 64'h3);
    chk("wr_wdata", {32'h0, f_mem_wdata}, 64'hABCD);
    f_req_addr = {32'h0000_0FFF, 32'h0}; f_req_wstrb = 8'hFF; f_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("wr_hold_addr",  {32'h0, f_mem_addr}, 64'h40);
    chk("wr_hold_wstrb", {60'h0, f_mem_wstrb}, 64'h3);
    chk("wr_hold_wdata", {32'h0, f_mem_wdata}, 64'hABCD);
    f_mem_valid = 1'b1; f_mem_rdata = 32'h55AA_55AA;
    tick();
    f_mem_valid = 1'b0; f_req_ready = 2'b00; f_req_wstrb = 8'h00;
    chk("wr_valid", {62'h0, f_req_valid}, 64'h2);
    tick();

    // watchdog: memory never answers
    f_req_addr = {32'h0, 32'h0000_0300};
    f_req_ready = 2'b01;
    tick();
    chk("to_ready_rise", {63'h0, f_mem_ready}, 64'h1);
    tick(); tick(); tick();
    chk("to_still_busy", {63'h0, f_mem_ready}, 64'h1);
    chk("to_no_valid",   {62'h0, f_req_valid}, 64'h0);
    tick();
    chk("to_valid", {62'h0, f_req_valid}, 64'h1);
    chk("to_err",   {63'h0, f_req_err}, 64'h1);
    chk("to_rdata", {32'h0, f_req_rdata}, 64'h0);
    chk("to_ready", {63'h0, f_mem_ready}, 64'h0);
    f_req_ready = 2'b00;
    tick();
    chk("to_clr_valid", {62'h0, f_req_valid}, 64'h0);
    chk("to_clr_err",   {63'h0, f_req_err}, 64'h0);

    // watchdog boundary: completion in the 4th BUSY cycle wins
    f_req_ready = 2'b01;
    tick(); tick(); tick(); tick();
    f_mem_valid = 1'b1; f_mem_rdata = 32'hCAFE_F00D;
    tick();
    f_mem_valid = 1'b0; f_req_ready = 2'b00;
    chk("tb_valid", {62'h0, f_req_valid}, 64'h1);
    chk("tb_err",   {63'h0, f_req_err}, 64'h0);
    chk("tb_rdata", {32'h0, f_req_rdata}, 64'hCAFE_F00D);
    tick();

    // round-robin: all ports requesting continuously
    r_req_ready = 3'b111;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_addr", {32'h0, r_mem_addr}, 64'h1000 + 64'(exp_order[i]) * 64'h10);
      r_mem_valid = 1'b1; r_mem_rdata = 32'(i);
      tick();
      r_mem_valid = 1'b0;
      chk("rr_valid", {61'h0, r_req_valid}, 64'h1 << exp_order[i]);
      tick();
    end
    // one more grant to port 0 leaves the pointer at 0
    tick();
    chk("rr_g10", {32'h0, r_mem_addr}, 64'h1000);
    r_mem_valid = 1'b1;
    tick();
    r_mem_valid = 1'b0;
    tick();
    tick();
    chk("rr_g11", {32'h0, r_mem_addr}, 64'h1010);
    tick();
    r_reset = 1'b1;
    tick();
    chk("rst_busy_ready", {63'h0, r_mem_ready}, 64'h0);
    chk("rst_busy_valid", {61'h0, r_req_valid}, 64'h0);
    r_reset = 1'b0;
    r_req_ready = 3'b011;
    tick();
    chk("rst_ptr_addr",  {32'h0, r_mem_addr}, 64'h1000);
    chk("rst_ptr_ready", {63'h0, r_mem_ready}, 64'h1);
    r_mem_valid = 1'b1;
    tick();
    r_mem_valid = 1'b0;
    chk("rst_ptr_valid", {61'h0, r_req_valid}, 64'h1);
    r_req_ready = 3'b010;
    tick();
    tick();
    chk("rst_p1_addr",  {32'h0, r_mem_addr}, 64'h1010);
    chk("rst_p1_ready", {63'h0, r_mem_ready}, 64'h1);
    r_mem_valid = 1'b1;
    tick();
    r_mem_valid = 1'b0; r_req_ready = 3'b000;
    chk("rst_p1_valid", {61'h0, r_req_valid}, 64'h2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-port arbiter for the single shared memory bus between the core's memory-using stages (fetcher, accessor, future DMA/debug).
- Replaces the OR-ed mem_ready sharing in the CPU top level.
- Only one transaction is outstanding at a time.
- Grants by fixed priority or round-robin, latches the winner's request, and drives the memory bus.
- Returns a one-cycle completion pulse with registered read data.
- An optional watchdog aborts hung transactions.

Parameters:
- NUM_PORTS, 2, number of requesters (≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 0, cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- req_ready  in  NUM_PORTS  per-port request. Must be held until that port's req_valid.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed as req_addr.
- req_wstrb  in  NUM_PORTS*DATA_WIDTH/8  packed; 0 means read.
- req_instr  in  NUM_PORTS  instruction-fetch flag.
- req_valid  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- req_err  out  1  qualifies req_valid; 1 means the transaction timed out.
- req_rdata  out  DATA_WIDTH  registered read data, shared by all ports.
- mem_ready  out  1  memory request.
- mem_valid  in  1  memory completion.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wstrb  out  DATA_WIDTH/8  memory write strobe.
- mem_instr  out  1  memory instruction-fetch flag.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE; all outputs 0; round-robin pointer = NUM_PORTS-1, so port 0 is first; watchdog counter 0.
- Reset mid-BUSY aborts with no req_valid pulse. mem_ready is low after the reset edge.
- IDLE:
  - If any req_ready bit is set, pick the winner.
  - Fixed priority: lowest set index wins.
  - Round-robin: first set index strictly after the pointer, mod NUM_PORTS.
  - Latch the winner's addr, wdata, wstrb and instr into mem_* registers. Set mem_ready=1. Record the grant index. Go to BUSY.
  - Latency: request seen at edge t gives mem_ready high from t+1.
- BUSY:
  - mem_* outputs are stable. Requester-side changes are ignored.
  - On mem_valid: capture mem_rdata into req_rdata, pulse req_valid[grant] with req_err=0, drop mem_ready, update the round-robin pointer to grant, go to DONE.
  - All these updates are registered and visible the cycle after mem_valid.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle without mem_valid.
  - When count == TIMEOUT-1 and mem_valid is low, abort: req_valid[grant]=1, req_err=1, req_rdata=0, mem_ready=0, go to DONE.
  - mem_valid in the same cycle as the timeout wins, and completes normally.
- DONE:
  - Lasts exactly one cycle. req_valid is high here.
  - No arbitration, so the completing port can withdraw its request. Then go to IDLE.
  - req_valid and req_err return to 0 on leaving DONE.
- Back-to-back throughput is one transaction per (memory latency + 2) cycles.
- mem_valid in IDLE or DONE is ignored; no state change, and req_rdata is unchanged.
- req_rdata holds its value until the next completion.
- For writes, the captured rdata is don't-care but is still registered.
- A request dropped before its grant is legal: it is simply not picked.
- A request dropped during BUSY is a protocol violation. The arbiter still completes the transaction.
- Round-robin guarantee: with all ports requesting continuously, each port is granted exactly once per NUM_PORTS grants.

Decomposition:
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - ARB_FIXED=0 and ARB_ROUND_ROBIN=1 constants;
  - a function returning the strobe width for a data width.
- One combinational sub-module, arb_picker:
  - inputs: request vector, pointer, mode;
  - outputs: one-hot grant, grant index, any_req.
- The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Fixed priority, NUM_PORTS=2:
  - Ports 0 and 1 request together: port 0 (addr 0x100) is granted.
  - Memory returns mem_valid 3 cycles later with 0xDEADBEEF: req_valid[0] pulses one cycle with req_rdata=0xDEADBEEF.
  - Port 1 (addr 0x200) is then granted; mem_ready rises 2 cycles after req_valid[0].
- Round-robin, NUM_PORTS=3, all requesting continuously for 9 grants: grant order is 0,1,2,0,1,2,0,1,2.
- Write passthrough: port 1 with wstrb=4'b0011, wdata=0x0000ABCD, addr 0x40 gives mem_addr=0x40, mem_wstrb=0011, mem_wdata=0x0000ABCD, stable through BUSY.
- TIMEOUT=4, memory never answers: 4 cycles after mem_ready rises, req_valid[grant]=1 with req_err=1 and req_rdata=0, and mem_ready is low.
- Timeout boundary, same TIMEOUT=4: mem_valid arrives exactly in the 4th BUSY cycle, giving req_err=0 and the normal data.
- Reset asserted during BUSY: the next cycle has mem_ready=0 and no req_valid. After release with port 1 requesting, port 1 is granted and the round-robin pointer restarts at port 0 priority.
- Spurious mem_valid in IDLE with 0x12345678 on mem_rdata: req_rdata is unchanged and no req_valid pulses.
